seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 78 +++++++
 tb/tb_seg_scan_driver.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit multiplexed 7-segment scanner with one-cycle dead time between digits.
// Define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_driver #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    output logic [6:0]  display,
    output logic [3:0]  en_n,
    output logic        h
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   value_reg;
    logic          valid, tick, blank;
    logic [3:0]    nib;
    logic [6:0]    seg;

    assign h = 1'b1;

    // Decode from the post-tick index so the new digit lands during the dead-time cycle
    always_comb begin
        tick    = cnt == CW'(DIV - 1);
        idx_nxt = tick ? idx + 2'd1 : idx;
        nib     = idx_nxt == 2'd0 ? value_reg[15:12] :
                  idx_nxt == 2'd1 ? value_reg[11:8]  :
                  idx_nxt == 2'd2 ? value_reg[7:4]   : value_reg[3:0];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        blank   = (idx_nxt == 2'd0 && value_reg[15:12] == 4'h0) ||
                  (idx_nxt == 2'd1 && value_reg[15:8] == 8'h00) ||
                  (idx_nxt == 2'd2 && value_reg[15:4] == 12'h000);
`else
        blank   = 1'b0;
`endif
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            idx       <= 2'd0;
            value_reg <= 16'h0000;
            valid     <= 1'b0;
            display   <= 7'h7f;
            en_n      <= 4'hf;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            idx     <= idx_nxt;
            display <= (valid && !blank) ? seg : 7'h7f;
            en_n    <= (!valid || tick) ? 4'hf : ~(4'b0001 << idx_nxt);
            if (load) begin
                value_reg <= value;
                valid     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of scan order, dead time, load timing and reset for DIV=4.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [6:0]  display;
    logic [3:0]  en_n;
    logic        h;
    int          total = 0;
    int          bad = 0;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] Z = LZB ? OFF : 7'b0000001;

    seg_scan_driver #(.DIV(4)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .display(display), .en_n(en_n), .h(h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sc(input string tag, input logic [6:0] d, input logic [3:0] e);
        step();
        chk({tag, ".disp"}, 16'(display), 16'(d));
        chk({tag, ".en"}, 16'(en_n), 16'(e));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // load during reset must be ignored
        load = 1'b1;
        value = 16'h1234;
        idle(3);
        chk("rst.disp", 16'(display), 16'(OFF));
        chk("rst.en", 16'(en_n), 16'hf);
        chk("rst.h", 16'(h), 16'h1);
        @(negedge clk);
        reset = 1'b1;
        load = 1'b0;
        for (int i = 0; i < 40; i++) sc("noload", OFF, 4'b1111);
        // k=40: load 0000, visible one edge after capture
        load = 1'b1;
        value = 16'h0000;
        sc("z.k41", OFF, 4'b1111);
        load = 1'b0;
        sc("z.k42", Z, 4'b1011);
        step();
        sc("z.k44", 7'b0000001, 4'b1111);
        sc("z.k45", 7'b0000001, 4'b0111);

        // realign with a fresh reset, load 1A3F on the first edge after release
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2.disp", 16'(display), 16'(OFF));
        @(negedge clk);
        reset = 1'b1;
        load = 1'b1;
        value = 16'h1A3F;
        sc("a.k1", OFF, 4'b1111);
        load = 1'b0;
        sc("a.k2", 7'b1001111, 4'b1110);
        sc("a.k3", 7'b1001111, 4'b1110);
        sc("a.k4", 7'b0001000, 4'b1111);
        sc("a.k5", 7'b0001000, 4'b1101);
        sc("a.k6", 7'b0001000, 4'b1101);
        sc("a.k7", 7'b0001000, 4'b1101);
        sc("a.k8", 7'b0000110, 4'b1111);
        sc("a.k9", 7'b0000110, 4'b1011);
        sc("a.k10", 7'b0000110, 4'b1011);
        sc("a.k11", 7'b0000110, 4'b1011);
        sc("a.k12", 7'b0111000, 4'b1111);
        sc("a.k13", 7'b0111000, 4'b0111);
        sc("a.k14", 7'b0111000, 4'b0111);
        sc("a.k15", 7'b0111000, 4'b0111);
        sc("a.k16", 7'b1001111, 4'b1111);
        sc("a.k17", 7'b1001111, 4'b1110);
        idle(14);
        // edge 32 is a tick at index 3: load coincides with the wrap
        load = 1'b1;
        value = 16'h5678;
        sc("w.k32", 7'b1001111, 4'b1111);
        load = 1'b0;
        sc("w.k33", 7'b0100100, 4'b1110);
        // back-to-back loads, last one wins, scan unaffected
        load = 1'b1;
        value = 16'h3000;
        sc("bb.k34", 7'b0100100, 4'b1110);
        value = 16'h8700;
        sc("bb.k35", 7'b0000110, 4'b1110);
        load = 1'b0;
        sc("bb.k36", 7'b0001111, 4'b1111);
        sc("bb.k37", 7'b0001111, 4'b1101);
        idle(4);
        // k=41: index 2, mid-slot; reset acts without a clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("mid.disp", 16'(display), 16'(OFF));
        chk("mid.en", 16'(en_n), 16'hf);
        chk("mid.h", 16'(h), 16'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        load = 1'b1;
        value = 16'h0042;
        sc("lz.k1", OFF, 4'b1111);
        load = 1'b0;
        sc("lz.k2", Z, 4'b1110);
        sc("lz.k3", Z, 4'b1110);
        sc("lz.k4", Z, 4'b1111);
        sc("lz.k5", Z, 4'b1101);
        idle(2);
        sc("lz.k8", 7'b1001100, 4'b1111);
        sc("lz.k9", 7'b1001100, 4'b1011);
        idle(2);
        sc("lz.k12", 7'b0010010, 4'b1111);
        sc("lz.k13", 7'b0010010, 4'b0111);
        chk("lz.h", 16'(h), 16'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
